// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp FSM state encoding and default duty/counter width.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter plus step divider; runs in lock-step with the PWM generator.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH            = PWM_WIDTH_DEFAULT,
  parameter int unsigned PERIODS_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic div_clr_i,
  output logic period_start_o,
  output logic period_end_c_o,
  output logic step_tick_c_o
);

  localparam int unsigned DIV_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [WIDTH-1:0] PCNT_LAST = {WIDTH{1'b1}};
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PERIODS_PER_STEP - 1);

  logic [WIDTH-1:0] pcnt_q;
  logic [DIV_W-1:0] divcnt_q;
  logic [DIV_W-1:0] divcnt_d;
  logic             period_start_q;

  assign period_end_c_o = (pcnt_q == PCNT_LAST);
  // A divider clear (target accept) suppresses a coincident tick.
  assign step_tick_c_o  = period_end_c_o && (divcnt_q == DIV_LAST) && !div_clr_i;
  assign period_start_o = period_start_q;

  always_comb begin
    divcnt_d = divcnt_q;
    if (div_clr_i) begin
      divcnt_d = '0;
    end else if (period_end_c_o) begin
      divcnt_d = (divcnt_q == DIV_LAST) ? '0 : divcnt_q + DIV_W'(1);
    end
  end

  // period_start is registered from period_end so it is high while pcnt == 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q         <= '0;
      divcnt_q       <= '0;
      period_start_q <= 1'b1;
    end else begin
      pcnt_q         <= pcnt_q + WIDTH'(1);
      divcnt_q       <= divcnt_d;
      period_start_q <= period_end_c_o;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew stage for the PWM generator: accepts a target and steps toward it at period boundaries.
// Optional PWM_RAMP_BREATHE_EN adds the breathe_i port (bounce between target and 0).
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH            = PWM_WIDTH_DEFAULT,
  parameter int unsigned STEP             = 1,
  parameter int unsigned PERIODS_PER_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid_i,
  input  logic [WIDTH-1:0] tgt_duty_i,
  output logic             tgt_ready_o,
  output logic [WIDTH-1:0] duty_cycle_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             period_start_o
`ifdef PWM_RAMP_BREATHE_EN
  ,
  input  logic             breathe_i
`endif
);

  ramp_state_t      state_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] dest_q;
  logic [WIDTH-1:0] duty_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic             accept_c;
  logic             breathe_c;
  logic             period_end_c;
  logic             step_tick_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] up_d;
  logic [WIDTH-1:0] down_d;
  logic [WIDTH-1:0] step_d;

`ifdef PWM_RAMP_BREATHE_EN
  assign breathe_c = breathe_i;
`else
  assign breathe_c = 1'b0;
`endif

  assign accept_c       = tgt_valid_i && ready_q;
  assign tgt_ready_o    = ready_q;
  assign duty_cycle_o   = duty_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

  pwm_period_timer #(
    .WIDTH            (WIDTH),
    .PERIODS_PER_STEP (PERIODS_PER_STEP)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .div_clr_i      (accept_c),
    .period_start_o (period_start_o),
    .period_end_c_o (period_end_c),
    .step_tick_c_o  (step_tick_c)
  );

  // Saturating step toward dest_q: one extra sum bit prevents wrap, diff compare prevents underflow.
  always_comb begin
    sum_c  = {1'b0, duty_q} + (WIDTH+1)'(STEP);
    up_d   = (sum_c >= {1'b0, dest_q}) ? dest_q : sum_c[WIDTH-1:0];
    diff_c = duty_q - dest_q;
    down_d = (diff_c <= WIDTH'(STEP)) ? dest_q : duty_q - WIDTH'(STEP);
    step_d = (state_q == RAMP_UP) ? up_d : down_d;
  end

  // dest_q is the current ramp endpoint: tgt_q normally, 0 on the down leg of a breathe cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      dest_q  <= '0;
      duty_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            tgt_q  <= tgt_duty_i;
            dest_q <= tgt_duty_i;
            if (tgt_duty_i > duty_q) begin
              state_q <= RAMP_UP;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end else if (tgt_duty_i < duty_q) begin
              state_q <= RAMP_DOWN;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (period_end_c && step_tick_c) begin
            duty_q <= step_d;
            if (step_d == dest_q) begin
              if (breathe_c && (tgt_q != '0) && (step_d == tgt_q)) begin
                state_q <= RAMP_DOWN;
                dest_q  <= '0;
              end else if (breathe_c && (tgt_q != '0) && (step_d == '0)) begin
                state_q <= RAMP_UP;
                dest_q  <= tgt_q;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ready_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: three instances (STEP/P = 1/4, 16/1, 64/1), directed targets.
module tb_pwm_duty_ramp;

  localparam int NI = 3;

  typedef struct {
    bit is_done;
    int val;
    int due;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       vld  [NI];
  logic [7:0] dat  [NI];
  logic       rdy  [NI];
  logic [7:0] duty [NI];
  logic       busy [NI];
  logic       done [NI];
  logic       ps   [NI];
  logic       brth;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] tb_pcnt;
  ev_t        evq [NI][$];
  int         prev_duty [NI];
  ev_t        e;

  pwm_duty_ramp #(.WIDTH(8), .STEP(1), .PERIODS_PER_STEP(4)) u_a (
    .clk(clk), .rst(rst), .tgt_valid_i(vld[0]), .tgt_duty_i(dat[0]), .tgt_ready_o(rdy[0]),
    .duty_cycle_o(duty[0]), .busy_o(busy[0]), .done_o(done[0]), .period_start_o(ps[0])
`ifdef PWM_RAMP_BREATHE_EN
    , .breathe_i(1'b0)
`endif
  );

  pwm_duty_ramp #(.WIDTH(8), .STEP(16), .PERIODS_PER_STEP(1)) u_b (
    .clk(clk), .rst(rst), .tgt_valid_i(vld[1]), .tgt_duty_i(dat[1]), .tgt_ready_o(rdy[1]),
    .duty_cycle_o(duty[1]), .busy_o(busy[1]), .done_o(done[1]), .period_start_o(ps[1])
`ifdef PWM_RAMP_BREATHE_EN
    , .breathe_i(1'b0)
`endif
  );

  pwm_duty_ramp #(.WIDTH(8), .STEP(64), .PERIODS_PER_STEP(1)) u_c (
    .clk(clk), .rst(rst), .tgt_valid_i(vld[2]), .tgt_duty_i(dat[2]), .tgt_ready_o(rdy[2]),
    .duty_cycle_o(duty[2]), .busy_o(busy[2]), .done_o(done[2]), .period_start_o(ps[2])
`ifdef PWM_RAMP_BREATHE_EN
    , .breathe_i(brth)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference period counter: increments every clk, cleared by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_pcnt <= 8'd0;
    else      tb_pcnt <= tb_pcnt + 8'd1;
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %0d expected %0d", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int i, input bit is_done, input int val, input int due);
    ev_t x;
    x.is_done = is_done;
    x.val     = val;
    x.due     = due;
    evq[i].push_back(x);
  endtask

  // Monitor: every duty change or done pulse must match the head of the instance's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        evq[i].delete();
        prev_duty[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        chk("period_start", i, int'(ps[i]), int'(tb_pcnt == 8'd0));
        if (int'(duty[i]) != prev_duty[i]) begin
          prev_duty[i] = int'(duty[i]);
          chk("duty_event_expected", i, int'(evq[i].size() > 0), 1);
          if (evq[i].size() > 0) begin
            e = evq[i].pop_front();
            chk("duty_event_kind", i, 0, int'(e.is_done));
            chk("duty_value", i, int'(duty[i]), e.val);
            chk("duty_cycle_time", i, cyc, e.due);
            chk("duty_at_pcnt0", i, int'(tb_pcnt), 0);
          end
        end
        if (done[i]) begin
          chk("done_event_expected", i, int'(evq[i].size() > 0), 1);
          if (evq[i].size() > 0) begin
            e = evq[i].pop_front();
            chk("done_event_kind", i, 1, int'(e.is_done));
            chk("done_duty", i, int'(duty[i]), e.val);
            chk("done_cycle_time", i, cyc, e.due);
            chk("done_busy_low", i, int'(busy[i]), 0);
          end
        end
      end
    end
  end

  task automatic wait_pcnt(input int k);
    int n = 0;
    @(negedge clk);
    while (int'(tb_pcnt) != k && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pcnt_timeout", 0, int'(tb_pcnt), k);
  endtask

  task automatic wait_cyc(input int d);
    while (cyc < d + 2) @(negedge clk);
  endtask

  // Called on a negedge; holds valid until the DUT shows ready, drops it after the accept edge.
  task automatic send(input int i, input int v);
    int n = 0;
    vld[i] = 1'b1;
    dat[i] = 8'(v);
    while (!rdy[i] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", i, int'(rdy[i]), 1);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  // Accept target v with the accept edge at pcnt == k; steps expected every spc clk.
  task automatic ramp(input int i, input int v, input int k, input int q[$], input int spc,
                      output int last_due);
    int c;
    int d;
    wait_pcnt(k);
    c = cyc + 1;
    d = c + ((k == 255) ? spc : (255 - k) + spc - 256);
    foreach (q[j]) push_ev(i, 1'b0, q[j], d + j * spc);
    last_due = d + (q.size() - 1) * spc;
    push_ev(i, 1'b1, q[q.size() - 1], last_due);
    send(i, v);
  endtask

  initial begin
    int v[$];
    int ld;
    int c;
    rst  = 1'b0;
    brth = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_duty", i, int'(duty[i]), 0);
      chk("rst_ready", i, int'(rdy[i]), 1);
      chk("rst_busy", i, int'(busy[i]), 0);
      chk("rst_done", i, int'(done[i]), 0);
      chk("rst_period_start", i, int'(ps[i]), 1);
    end
    rst = 1'b1;

    // STEP=1, P=4: 0 -> 3, then 3 -> 5 accepted on a period_end cycle.
    v = '{1, 2, 3};
    ramp(0, 3, 100, v, 1024, ld);
    wait_cyc(ld);
    v = '{4, 5};
    ramp(0, 5, 255, v, 1024, ld);
    wait_cyc(ld);

    // STEP=16, P=1: saturating up/down and held-off valid.
    v = '{16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 208, 224, 240, 250};
    ramp(1, 250, 40, v, 256, ld);
    chk("ramp_busy", 1, int'(busy[1]), 1);
    chk("ramp_ready_low", 1, int'(rdy[1]), 0);
    push_ev(1, 1'b0, 255, ld + 256);
    push_ev(1, 1'b1, 255, ld + 256);
    send(1, 255);
    wait_cyc(ld + 256);
    v = '{239, 223, 207, 191, 175, 159, 143, 127, 111, 95, 79, 63, 47, 31, 15, 10};
    ramp(1, 10, 7, v, 256, ld);
    wait_cyc(ld);
    wait_pcnt(30);
    c = cyc + 1;
    push_ev(1, 1'b1, 10, c);
    send(1, 10);
    repeat (3) @(negedge clk);
    chk("equal_busy", 1, int'(busy[1]), 0);
    v = '{0};
    ramp(1, 0, 200, v, 256, ld);
    wait_cyc(ld);

`ifdef PWM_RAMP_BREATHE_EN
    // STEP=64, P=1 breathing between 128 and 0, breathe dropped on a down leg.
    brth = 1'b1;
    v = '{64, 128, 64, 0, 64, 128, 64, 0};
    ramp(2, 128, 50, v, 256, ld);
    wait_cyc(ld - 4 * 256);
    chk("breathe_ready_low", 2, int'(rdy[2]), 0);
    chk("breathe_busy", 2, int'(busy[2]), 1);
    wait_cyc(ld - 256);
    brth = 1'b0;
    wait_cyc(ld);
`else
    v = '{64, 128};
    ramp(2, 128, 50, v, 256, ld);
    wait_cyc(ld);
`endif

    for (int i = 0; i < NI; i++) chk("events_left", i, evq[i].size(), 0);

    // Reset in the middle of a ramp.
    v = '{16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 200};
    ramp(1, 200, 0, v, 256, ld);
    repeat (700) @(negedge clk);
    chk("pre_reset_busy", 1, int'(busy[1]), 1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_duty", i, int'(duty[i]), 0);
      chk("midrst_busy", i, int'(busy[i]), 0);
      chk("midrst_ready", i, int'(rdy[i]), 1);
      chk("midrst_done", i, int'(done[i]), 0);
      chk("midrst_period_start", i, int'(ps[i]), 1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_duty", 1, int'(duty[1]), 0);
    chk("post_rst_ready", 1, int'(rdy[1]), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
